// File: rtl/min_sec_down_timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: FSM encoding and BCD digit limits.
package min_sec_down_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    // Largest value of a ones digit and of a tens digit (minutes or seconds).
    localparam int DIG_MAX = 9;
    localparam int TEN_MAX = 5;

    // Storage widths for the two kinds of digit.
    localparam int DIG_W = 4;
    localparam int TEN_W = 3;

endpackage

// File: rtl/min_sec_down_timer_if.sv
// Control/display bundle of the countdown timer.
// Inputs are single-CLK pulses that act on the next posedge; outputs are
// registered digits plus flags decoded from the registered state.
// STATE is a debug copy of the FSM state register.
interface min_sec_down_timer_if;
    import min_sec_down_timer_pkg::*;

    logic               EN;
    logic               START;
    logic               CLR;
    logic               INC_MIN;
    logic               INC_SEC;
    logic [TEN_W-1:0]   MH;
    logic [DIG_W-1:0]   ML;
    logic [TEN_W-1:0]   SH;
    logic [DIG_W-1:0]   SL;
    logic               RUNNING;
    logic               DONE;
    logic               BUZZ;
    state_t             STATE;

    // Driver side (buttons, 1 Hz tick generator, display).
    modport master (
        output EN, START, CLR, INC_MIN, INC_SEC,
        input  MH, ML, SH, SL, RUNNING, DONE, BUZZ, STATE
    );

    // Timer side.
    modport slave (
        input  EN, START, CLR, INC_MIN, INC_SEC,
        output MH, ML, SH, SL, RUNNING, DONE, BUZZ, STATE
    );

endinterface

// File: rtl/min_sec_down_timer_bcd_dn_digit.sv
// One BCD digit that can be cleared, decremented (0 wraps to MAX) or
// incremented (MAX wraps to 0). Borrow/carry are combinational so a chain of
// digits ripples within one cycle.
module min_sec_down_timer_bcd_dn_digit #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         borrow,
    output logic         carry
);
    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next digit value: clear wins, then decrement, then increment.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (dec) begin
            q_d = (q_q == '0) ? MAXV : q_q - W'(1);
        end else if (inc) begin
            q_d = (q_q == MAXV) ? '0 : q_q + W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q      = q_q;
    assign borrow = dec && (q_q == '0);
    assign carry  = inc && (q_q == MAXV);

endmodule

// File: rtl/min_sec_down_timer.sv
// MM:SS countdown timer with BCD digits. Set with +1 buttons, start/pause
// with START, clear with CLR; on reaching 00:00 it raises DONE/BUZZ for
// BUZZ_LEN EN ticks (or until START) before returning to IDLE.
module min_sec_down_timer
    import min_sec_down_timer_pkg::*;
#(
    parameter int BUZZ_LEN = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    min_sec_down_timer_if.slave   bus
);
    localparam int BW = $clog2(BUZZ_LEN + 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_LEN - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] buzz_q, buzz_d;

    logic clr_dig, dec_sec, inc_sec, inc_min;

    logic [TEN_W-1:0] mh, sh;
    logic [DIG_W-1:0] ml, sl;
    logic sl_borrow, sh_borrow, ml_borrow, mh_borrow;
    logic sl_carry, sh_carry, ml_carry, mh_carry;

    logic is_zero, is_one;

    assign is_zero = (mh == '0) && (ml == '0) && (sh == '0) && (sl == '0);
    assign is_one  = (mh == '0) && (ml == '0) && (sh == '0) && (sl == DIG_W'(1));

    // Next state, buzz count and digit controls; CLR beats START beats EN/INC.
    always_comb begin
        state_d = state_q;
        buzz_d  = buzz_q;
        clr_dig = 1'b0;
        dec_sec = 1'b0;
        inc_sec = 1'b0;
        inc_min = 1'b0;
        if (bus.CLR) begin
            state_d = S_IDLE;
            buzz_d  = '0;
            clr_dig = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        if (!is_zero) state_d = S_RUN;
                    end else begin
                        inc_sec = bus.INC_SEC;
                        inc_min = bus.INC_MIN;
                    end
                end
                S_RUN: begin
                    if (bus.START) begin
                        state_d = S_PAUSE;
                    end else if (bus.EN) begin
                        dec_sec = 1'b1;
                        // Last second expires: the digits land on 00:00 this edge.
                        if (is_one) state_d = S_ALARM;
                    end
                end
                S_PAUSE: begin
                    if (bus.START) state_d = S_RUN;
                end
                S_ALARM: begin
                    if (bus.START) begin
                        state_d = S_IDLE;
                        buzz_d  = '0;
                    end else if (bus.EN) begin
                        if (buzz_q == BUZZ_LAST) begin
                            state_d = S_IDLE;
                            buzz_d  = '0;
                        end else begin
                            buzz_d = buzz_q + BW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and buzz-count registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            buzz_q  <= '0;
        end else begin
            state_q <= state_d;
            buzz_q  <= buzz_d;
        end
    end

    // Seconds ones: decremented by EN, incremented by INC_SEC.
    min_sec_down_timer_bcd_dn_digit #(.MAX(DIG_MAX), .W(DIG_W)) u_sl (
        .clk(CLK), .rst(RST), .dec(dec_sec), .inc(inc_sec), .clr(clr_dig),
        .q(sl), .borrow(sl_borrow), .carry(sl_carry)
    );

    // Seconds tens: its carry is dropped so INC_SEC never touches minutes.
    min_sec_down_timer_bcd_dn_digit #(.MAX(TEN_MAX), .W(TEN_W)) u_sh (
        .clk(CLK), .rst(RST), .dec(sl_borrow), .inc(sl_carry), .clr(clr_dig),
        .q(sh), .borrow(sh_borrow), .carry(sh_carry)
    );

    // Minutes ones.
    min_sec_down_timer_bcd_dn_digit #(.MAX(DIG_MAX), .W(DIG_W)) u_ml (
        .clk(CLK), .rst(RST), .dec(sh_borrow), .inc(inc_min), .clr(clr_dig),
        .q(ml), .borrow(ml_borrow), .carry(ml_carry)
    );

    // Minutes tens: never borrows out, since 00:01 goes to ALARM instead.
    min_sec_down_timer_bcd_dn_digit #(.MAX(TEN_MAX), .W(TEN_W)) u_mh (
        .clk(CLK), .rst(RST), .dec(ml_borrow), .inc(ml_carry), .clr(clr_dig),
        .q(mh), .borrow(mh_borrow), .carry(mh_carry)
    );

    logic unused_chain;
    assign unused_chain = ^{mh_borrow, mh_carry, sh_carry};

    assign bus.MH      = mh;
    assign bus.ML      = ml;
    assign bus.SH      = sh;
    assign bus.SL      = sl;
    assign bus.RUNNING = (state_q == S_RUN);
    assign bus.DONE    = (state_q == S_ALARM);
    assign bus.BUZZ    = (state_q == S_ALARM);
    assign bus.STATE   = state_q;

endmodule
